// File: rtl/out_dma.sv
// Single-burst AXI write master: streams burst_len beats from the output buffer to one INCR burst.
// Define OUT_DMA_BRESP_CHECK_EN to flag a non-OKAY write response in dma_err.
module out_dma #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 9
) (
  input  logic                clk,
  input  logic                rst,
  // command / status
  input  logic                dma_start,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [LEN_W-1:0]    burst_len,
  output logic                busy,
  output logic                dma_done,
  output logic                dma_err,
  // stream in
  input  logic [DATA_W-1:0]   data_in,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  // AXI AW
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  // AXI W
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI B
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [2:0] AwSize = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  len_m1;

  assign len_m1 = len_q - LEN_W'(1);

  assign busy     = (state_q != StIdle);
  assign awvalid  = (state_q == StAw);
  assign awaddr   = addr_q;
  assign awlen    = 8'(len_m1);
  assign awsize   = AwSize;
  assign awburst  = 2'b01;
  // W channel is a pure pass-through of the stream, gated by state.
  assign wdata    = data_in;
  assign wstrb    = '1;
  assign wvalid   = (state_q == StW) && in_valid;
  assign in_ready = (state_q == StW) && wready;
  assign wlast    = (state_q == StW) && (cnt_q == len_m1);
  assign bready   = (state_q == StB);

`ifndef OUT_DMA_BRESP_CHECK_EN
  logic unused_bresp;
  assign unused_bresp = ^bresp;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      dma_done <= 1'b0;
      dma_err  <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (dma_start) begin
            if (burst_len != '0) begin
              addr_q  <= addr;
              len_q   <= burst_len;
              cnt_q   <= '0;
              dma_err <= 1'b0;
              state_q <= StAw;
            end else begin
              // Zero-length command completes immediately without bus traffic.
              dma_done <= 1'b1;
            end
          end
        end
        StAw: begin
          if (awready) begin
            cnt_q   <= '0;
            state_q <= StW;
          end
        end
        StW: begin
          if (in_valid && wready) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (in_last != wlast) dma_err <= 1'b1;
            if (wlast) state_q <= StB;
          end
        end
        StB: begin
          if (bvalid) begin
`ifdef OUT_DMA_BRESP_CHECK_EN
            if (bresp != 2'b00) dma_err <= 1'b1;
`endif
            dma_done <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_out_dma.sv
// Directed bench for out_dma: table of burst commands plus hand-written reset/restart sequences.
module tb_out_dma;

  logic        clk;
  logic        rst;
  logic        dma_start;
  logic [31:0] addr;
  logic [8:0]  burst_len;
  logic        busy, dma_done, dma_err;
  logic [31:0] data_in;
  logic        in_valid, in_last, in_ready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int checks = 0;
  int errors = 0;

  out_dma dut (
    .clk(clk), .rst(rst),
    .dma_start(dma_start), .addr(addr), .burst_len(burst_len),
    .busy(busy), .dma_done(dma_done), .dma_err(dma_err),
    .data_in(data_in), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          last_idx;   // beat carrying in_last; -1 means never
    bit          wtoggle;
    bit          rnd_valid;
    int          awdelay;
    int          bdelay;
    logic [1:0]  bresp;
    bit          early_b;    // bvalid held high before B
    bit          restart;    // dma_start pulsed in the B handshake cycle
    logic [7:0]  exp_awlen;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awvalid"}, 64'(awvalid), 0);
    chk({tag, "_wvalid"}, 64'(wvalid), 0);
    chk({tag, "_bready"}, 64'(bready), 0);
    chk({tag, "_in_ready"}, 64'(in_ready), 0);
    chk({tag, "_done"}, 64'(dma_done), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_err"}, 64'(dma_err), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int beat;
    int cyc;
    logic [31:0] d;
    @(negedge clk);
    dma_start = 1'b1; addr = v.addr; burst_len = 9'(v.len);
    #1 chk("idle_busy", 64'(busy), 0);
    @(negedge clk);
    // Command inputs change after the start edge; the latched copy must be used.
    dma_start = 1'b0; addr = 32'hDEAD_BEEF; burst_len = 9'd0;
    if (v.len == 0) begin
      #1;
      chk("zl_done", 64'(dma_done), 1);
      chk("zl_busy", 64'(busy), 0);
      chk("zl_awvalid", 64'(awvalid), 0);
      @(negedge clk);
      #1;
      chk("zl_done_clr", 64'(dma_done), 0);
      chk("zl_busy2", 64'(busy), 0);
      chk("zl_awvalid2", 64'(awvalid), 0);
      return;
    end
    bvalid = v.early_b;
    for (int i = 0; i <= v.awdelay; i++) begin
      awready = (i == v.awdelay);
      in_valid = 1'b1; wready = 1'b1;
      #1;
      chk("aw_valid", 64'(awvalid), 1);
      chk("aw_addr", 64'(awaddr), 64'(v.addr));
      chk("aw_len", 64'(awlen), 64'(v.exp_awlen));
      chk("aw_size", 64'(awsize), 2);
      chk("aw_burst", 64'(awburst), 1);
      chk("aw_wvalid", 64'(wvalid), 0);
      chk("aw_in_ready", 64'(in_ready), 0);
      chk("aw_bready", 64'(bready), 0);
      chk("aw_busy", 64'(busy), 1);
      chk("aw_done", 64'(dma_done), 0);
      @(negedge clk);
    end
    awready = 1'b0;
    beat = 0;
    cyc = 0;
    while (beat < v.len && cyc < 3000) begin
      in_valid = v.rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      wready = v.wtoggle ? ((cyc % 2) == 0) : 1'b1;
      d = 32'hD000_0000 + 32'(beat);
      data_in = d;
      in_last = (beat == v.last_idx);
      #1;
      chk("w_wvalid", 64'(wvalid), 64'(in_valid));
      chk("w_in_ready", 64'(in_ready), 64'(wready));
      chk("w_wdata", 64'(wdata), 64'(d));
      chk("w_wstrb", 64'(wstrb), 64'hF);
      chk("w_wlast", 64'(wlast), 64'(beat == v.len - 1));
      chk("w_awvalid", 64'(awvalid), 0);
      chk("w_bready", 64'(bready), 0);
      chk("w_done", 64'(dma_done), 0);
      if (in_valid && wready) beat++;
      cyc++;
      @(negedge clk);
    end
    chk("w_beats_timeout", 64'(beat), 64'(v.len));
    in_valid = 1'b0; wready = 1'b0; in_last = 1'b0;
    for (int i = 0; i <= v.bdelay; i++) begin
      bvalid = (i == v.bdelay);
      bresp = (i == v.bdelay) ? v.bresp : 2'b00;
      dma_start = v.restart && (i == v.bdelay);
      addr = 32'h0BAD_0000; burst_len = 9'd5;
      #1;
      chk("b_bready", 64'(bready), 1);
      chk("b_busy", 64'(busy), 1);
      chk("b_wvalid", 64'(wvalid), 0);
      chk("b_done", 64'(dma_done), 0);
      @(negedge clk);
    end
    bvalid = 1'b0; bresp = 2'b00; dma_start = 1'b0; burst_len = 9'd0;
    #1;
    chk("end_done", 64'(dma_done), 1);
    chk("end_busy", 64'(busy), 0);
    chk("end_err", 64'(dma_err), 64'(v.exp_err));
    chk("end_bready", 64'(bready), 0);
    @(negedge clk);
    #1;
    chk("post_done", 64'(dma_done), 0);
    chk("post_busy", 64'(busy), 0);
    chk("post_awvalid", 64'(awvalid), 0);
    chk("post_err", 64'(dma_err), 64'(v.exp_err));
  endtask

  vec_t vecs[7];
  vec_t vrec;
  bit   bresp_err;

  initial begin
`ifdef OUT_DMA_BRESP_CHECK_EN
    bresp_err = 1'b1;
`else
    bresp_err = 1'b0;
`endif
    vecs[0] = '{addr: 32'h1000, len: 4, last_idx: 3, wtoggle: 0, rnd_valid: 0, awdelay: 0,
                bdelay: 0, bresp: 2'b00, early_b: 1, restart: 0, exp_awlen: 8'd3, exp_err: 0};
    vecs[1] = '{addr: 32'h2000, len: 256, last_idx: 255, wtoggle: 1, rnd_valid: 1, awdelay: 1,
                bdelay: 1, bresp: 2'b00, early_b: 0, restart: 0, exp_awlen: 8'd255, exp_err: 0};
    vecs[2] = '{addr: 32'h3000, len: 0, last_idx: -1, wtoggle: 0, rnd_valid: 0, awdelay: 0,
                bdelay: 0, bresp: 2'b00, early_b: 0, restart: 0, exp_awlen: 8'd0, exp_err: 0};
    vecs[3] = '{addr: 32'h40, len: 2, last_idx: 0, wtoggle: 0, rnd_valid: 0, awdelay: 0,
                bdelay: 0, bresp: 2'b00, early_b: 0, restart: 0, exp_awlen: 8'd1, exp_err: 1};
    vecs[4] = '{addr: 32'h5000, len: 3, last_idx: 2, wtoggle: 0, rnd_valid: 0, awdelay: 0,
                bdelay: 2, bresp: 2'b10, early_b: 0, restart: 0, exp_awlen: 8'd2,
                exp_err: bresp_err};
    vecs[5] = '{addr: 32'h6004, len: 1, last_idx: -1, wtoggle: 0, rnd_valid: 0, awdelay: 2,
                bdelay: 2, bresp: 2'b00, early_b: 0, restart: 1, exp_awlen: 8'd0, exp_err: 1};
    vecs[6] = '{addr: 32'h7000, len: 5, last_idx: 4, wtoggle: 1, rnd_valid: 0, awdelay: 0,
                bdelay: 0, bresp: 2'b00, early_b: 0, restart: 0, exp_awlen: 8'd4, exp_err: 0};

    rst = 1'b0; dma_start = 1'b0; addr = '0; burst_len = '0;
    data_in = '0; in_valid = 1'b0; in_last = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    #1 rst = 1'b1;
    #1 chk_all_zero("rst");
    @(negedge clk);
    dma_start = 1'b1; burst_len = 9'd4;
    @(negedge clk);
    #1 chk_all_zero("rst_hold");
    dma_start = 1'b0; burst_len = 9'd0;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Mid-burst reset, with a re-start attempt during AW that must be ignored.
    @(negedge clk);
    dma_start = 1'b1; addr = 32'h8000; burst_len = 9'd8;
    @(negedge clk);
    addr = 32'h9999; burst_len = 9'd7; awready = 1'b0;
    #1 chk("mr_awaddr0", 64'(awaddr), 64'h8000);
    @(negedge clk);
    dma_start = 1'b0; awready = 1'b1;
    #1;
    chk("mr_awaddr1", 64'(awaddr), 64'h8000);
    chk("mr_awlen1", 64'(awlen), 7);
    @(negedge clk);
    awready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; wready = 1'b1; data_in = 32'hC0 + 32'(i); in_last = (i == 0);
      @(negedge clk);
    end
    in_last = 1'b0;
    #1;
    chk("mr_err_set", 64'(dma_err), 1);
    chk("mr_wvalid", 64'(wvalid), 1);
    chk("mr_wlast", 64'(wlast), 0);
    rst = 1'b1;
    #1 chk_all_zero("mr_rst");
    @(negedge clk);
    #1 chk_all_zero("mr_rst_hold");
    rst = 1'b0; in_valid = 1'b0; wready = 1'b0;
    vrec = '{addr: 32'hA000, len: 1, last_idx: 0, wtoggle: 0, rnd_valid: 0, awdelay: 0,
             bdelay: 0, bresp: 2'b00, early_b: 0, restart: 0, exp_awlen: 8'd0, exp_err: 0};
    run_vec(vrec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
